// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle for decode_stage.
// The slave modport is the decode stage's view; the master modport is the
// view of the surrounding pipeline (fetch + execute), used by the testbench.
interface decode_stage_if #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int ILL_CNT_W = 8
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_inst;
    logic [PC_W-1:0]      in_pc;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic                 out_valid;
    logic                 out_ready;
    logic [5:0]           out_op;
    logic [XLEN-1:0]      out_imm;
    logic [4:0]           out_rd;
    logic [4:0]           out_rs1;
    logic [4:0]           out_rs2;
    logic [PC_W-1:0]      out_pc;
    logic                 out_illegal;
    logic [ILL_CNT_W-1:0] ill_cnt;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, out_op, out_imm,
               out_rd, out_rs1, out_rs2, out_pc, out_illegal, ill_cnt
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, out_op, out_imm,
               out_rd, out_rs1, out_rs2, out_pc, out_illegal, ill_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with valid/ready on both sides.
// Decodes into an op index (0 = illegal), builds the sign-extended immediate,
// supports flush and keeps a saturating count of accepted illegal instructions.
// Optional feature macro: DECODE_RV32M_EN (decode MUL..REMU as ops 41-48).
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);

    // Only a 32-bit datapath is meaningful for RV32I.
    if (XLEN != 32) begin : g_xlen_check
        $error("decode_stage: XLEN must be 32");
    end

    logic [31:0]          w_inst;
    logic [6:0]           w_opcode;
    logic [2:0]           w_funct3;
    logic [6:0]           w_funct7;
    logic [XLEN-1:0]      w_imm_i;
    logic [XLEN-1:0]      w_imm_s;
    logic [XLEN-1:0]      w_imm_b;
    logic [XLEN-1:0]      w_imm_u;
    logic [XLEN-1:0]      w_imm_j;
    logic [XLEN-1:0]      w_imm_sh;
    logic [5:0]           w_op;
    logic [XLEN-1:0]      w_imm;
    logic                 w_rd_zero;
    logic                 w_illegal;
    logic [XLEN-1:0]      w_imm_final;
    logic [4:0]           w_rd;
    logic                 w_in_ready;
    logic                 w_accept;

    logic                 r_valid;
    logic [5:0]           r_op;
    logic [XLEN-1:0]      r_imm;
    logic [4:0]           r_rd;
    logic [4:0]           r_rs1;
    logic [4:0]           r_rs2;
    logic [PC_W-1:0]      r_pc;
    logic                 r_illegal;
    logic [ILL_CNT_W-1:0] r_ill_cnt;

    assign w_inst   = bus.in_inst;
    assign w_opcode = w_inst[6:0];
    assign w_funct3 = w_inst[14:12];
    assign w_funct7 = w_inst[31:25];

    // Immediate candidates for every instruction format.
    assign w_imm_i  = {{(XLEN-12){w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s  = {{(XLEN-12){w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b  = {{(XLEN-13){w_inst[31]}}, w_inst[31], w_inst[7],
                       w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u  = {w_inst[31:12], 12'h000};
    assign w_imm_j  = {{(XLEN-21){w_inst[31]}}, w_inst[31], w_inst[19:12],
                       w_inst[20], w_inst[30:21], 1'b0};
    assign w_imm_sh = {{(XLEN-5){1'b0}}, w_inst[24:20]};

    // Opcode/funct decode into op index, raw immediate and rd-suppression flag.
    // The full 7-bit opcode match also enforces inst[1:0] == 2'b11.
    always_comb begin
        w_op      = 6'd0;
        w_imm     = {XLEN{1'b0}};
        w_rd_zero = 1'b0;
        case (w_opcode)
            7'b0110111: begin
                w_op  = 6'd1;
                w_imm = w_imm_u;
            end
            7'b0010111: begin
                w_op  = 6'd2;
                w_imm = w_imm_u;
            end
            7'b1101111: begin
                w_op  = 6'd3;
                w_imm = w_imm_j;
            end
            7'b1100111: begin
                w_imm = w_imm_i;
                if (w_funct3 == 3'b000) begin
                    w_op = 6'd4;
                end else begin
                    w_op = 6'd0;
                end
            end
            7'b1100011: begin
                w_imm     = w_imm_b;
                w_rd_zero = 1'b1;
                case (w_funct3)
                    3'b000:  w_op = 6'd5;
                    3'b001:  w_op = 6'd6;
                    3'b100:  w_op = 6'd7;
                    3'b101:  w_op = 6'd8;
                    3'b110:  w_op = 6'd9;
                    3'b111:  w_op = 6'd10;
                    default: w_op = 6'd0;
                endcase
            end
            7'b0000011: begin
                w_imm = w_imm_i;
                case (w_funct3)
                    3'b000:  w_op = 6'd11;
                    3'b001:  w_op = 6'd12;
                    3'b010:  w_op = 6'd13;
                    3'b100:  w_op = 6'd14;
                    3'b101:  w_op = 6'd15;
                    default: w_op = 6'd0;
                endcase
            end
            7'b0100011: begin
                w_imm     = w_imm_s;
                w_rd_zero = 1'b1;
                case (w_funct3)
                    3'b000:  w_op = 6'd16;
                    3'b001:  w_op = 6'd17;
                    3'b010:  w_op = 6'd18;
                    default: w_op = 6'd0;
                endcase
            end
            7'b0010011: begin
                w_imm = w_imm_i;
                case (w_funct3)
                    3'b000:  w_op = 6'd19;
                    3'b010:  w_op = 6'd20;
                    3'b011:  w_op = 6'd21;
                    3'b100:  w_op = 6'd22;
                    3'b110:  w_op = 6'd23;
                    3'b111:  w_op = 6'd24;
                    3'b001: begin
                        w_imm = w_imm_sh;
                        if (w_funct7 == 7'h00) begin
                            w_op = 6'd25;
                        end else begin
                            w_op = 6'd0;
                        end
                    end
                    3'b101: begin
                        w_imm = w_imm_sh;
                        if (w_funct7 == 7'h00) begin
                            w_op = 6'd26;
                        end else if (w_funct7 == 7'h20) begin
                            w_op = 6'd27;
                        end else begin
                            w_op = 6'd0;
                        end
                    end
                    default: w_op = 6'd0;
                endcase
            end
            7'b0110011: begin
                case (w_funct7)
                    7'h00: begin
                        case (w_funct3)
                            3'b000:  w_op = 6'd28;
                            3'b001:  w_op = 6'd30;
                            3'b010:  w_op = 6'd31;
                            3'b011:  w_op = 6'd32;
                            3'b100:  w_op = 6'd33;
                            3'b101:  w_op = 6'd34;
                            3'b110:  w_op = 6'd36;
                            3'b111:  w_op = 6'd37;
                            default: w_op = 6'd0;
                        endcase
                    end
                    7'h20: begin
                        case (w_funct3)
                            3'b000:  w_op = 6'd29;
                            3'b101:  w_op = 6'd35;
                            default: w_op = 6'd0;
                        endcase
                    end
`ifdef DECODE_RV32M_EN
                    7'h01: w_op = 6'd41 + {3'b000, w_funct3};
`else
                    7'h01: w_op = 6'd0;
`endif
                    default: w_op = 6'd0;
                endcase
            end
            7'b0001111: begin
                w_rd_zero = 1'b1;
                if (w_funct3 == 3'b000) begin
                    w_op = 6'd38;
                end else begin
                    w_op = 6'd0;
                end
            end
            7'b1110011: begin
                w_rd_zero = 1'b1;
                if (w_inst == 32'h0000_0073) begin
                    w_op = 6'd39;
                end else if (w_inst == 32'h0010_0073) begin
                    w_op = 6'd40;
                end else begin
                    w_op = 6'd0;
                end
            end
            default: w_op = 6'd0;
        endcase
    end

    assign w_illegal   = (w_op == 6'd0);
    assign w_imm_final = w_illegal ? {XLEN{1'b0}} : w_imm;
    assign w_rd        = w_rd_zero ? 5'd0 : w_inst[11:7];

    assign w_in_ready  = !r_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready && !bus.flush;

    // Pipeline register: flush wins, then accept, then drain on consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_op      <= 6'd0;
            r_imm     <= {XLEN{1'b0}};
            r_rd      <= 5'd0;
            r_rs1     <= 5'd0;
            r_rs2     <= 5'd0;
            r_pc      <= {PC_W{1'b0}};
            r_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_valid   <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_op      <= w_op;
            r_imm     <= w_imm_final;
            r_rd      <= w_rd;
            r_rs1     <= w_inst[19:15];
            r_rs2     <= w_inst[24:20];
            r_pc      <= bus.in_pc;
            r_illegal <= w_illegal;
        end else if (r_valid && bus.out_ready) begin
            r_valid   <= 1'b0;
        end else begin
            r_valid   <= r_valid;
        end
    end

    // Saturating count of illegal instructions actually accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ill_cnt <= {ILL_CNT_W{1'b0}};
        end else if (w_accept && w_illegal && (r_ill_cnt != {ILL_CNT_W{1'b1}})) begin
            r_ill_cnt <= r_ill_cnt + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_ill_cnt <= r_ill_cnt;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.rs1_addr    = w_inst[19:15];
    assign bus.rs2_addr    = w_inst[24:20];
    assign bus.out_valid   = r_valid;
    assign bus.out_op      = r_op;
    assign bus.out_imm     = r_imm;
    assign bus.out_rd      = r_rd;
    assign bus.out_rs1     = r_rs1;
    assign bus.out_rs2     = r_rs2;
    assign bus.out_pc      = r_pc;
    assign bus.out_illegal = r_illegal;
    assign bus.ill_cnt     = r_ill_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven directed bench for decode_stage, plus
// hand-written sequences for stall, flush, counter saturation and mid-stall reset.
module tb_decode_stage;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   exp_cnt;
    int   xfer_cnt;

    decode_stage_if #(.XLEN(32), .PC_W(32), .ILL_CNT_W(8)) bus ();

    decode_stage #(.XLEN(32), .PC_W(32), .ILL_CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  op;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed output transfers for the ordering check.
    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) xfer_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] inst, input logic [31:0] pc);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        #1;
        check("rs1_addr", {27'd0, bus.rs1_addr}, {27'd0, inst[19:15]});
        check("rs2_addr", {27'd0, bus.rs2_addr}, {27'd0, inst[24:20]});
        check("in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] inst;
        n_tests  = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        xfer_cnt = 0;

        vecs.push_back('{32'h0050_0093, 6'd19, 32'h0000_0005, 5'd1,  1'b0}); // addi x1,x0,5
        vecs.push_back('{32'h4020_81B3, 6'd29, 32'h0000_0000, 5'd3,  1'b0}); // sub x3,x1,x2
        vecs.push_back('{32'hFE00_0EE3, 6'd5,  32'hFFFF_FFFC, 5'd0,  1'b0}); // beq x0,x0,-4
        vecs.push_back('{32'h1234_52B7, 6'd1,  32'h1234_5000, 5'd5,  1'b0}); // lui x5
        vecs.push_back('{32'h0000_0000, 6'd0,  32'h0000_0000, 5'd0,  1'b1}); // all zero
`ifdef DECODE_RV32M_EN
        vecs.push_back('{32'h0231_00B3, 6'd41, 32'h0000_0000, 5'd1,  1'b0}); // mul
`else
        vecs.push_back('{32'h0231_00B3, 6'd0,  32'h0000_0000, 5'd1,  1'b1}); // mul (no M)
`endif
        vecs.push_back('{32'h6000_5013, 6'd0,  32'h0000_0000, 5'd0,  1'b1}); // shift funct7 0x30
        vecs.push_back('{32'h4000_5013, 6'd27, 32'h0000_0000, 5'd0,  1'b0}); // srai x0,x0,0
        vecs.push_back('{32'h0000_0073, 6'd39, 32'h0000_0000, 5'd0,  1'b0}); // ecall
        vecs.push_back('{32'h0010_0073, 6'd40, 32'h0000_0000, 5'd0,  1'b0}); // ebreak
        vecs.push_back('{32'h0020_0073, 6'd0,  32'h0000_0000, 5'd0,  1'b1}); // bad system
        vecs.push_back('{32'h0080_00EF, 6'd3,  32'h0000_0008, 5'd1,  1'b0}); // jal x1,8
        vecs.push_back('{32'hFE51_2C23, 6'd18, 32'hFFFF_FFF8, 5'd0,  1'b0}); // sw x5,-8(x2)
        vecs.push_back('{32'hFFF1_A383, 6'd13, 32'hFFFF_FFFF, 5'd7,  1'b0}); // lw x7,-1(x3)
        vecs.push_back('{32'hFFFF_F517, 6'd2,  32'hFFFF_F000, 5'd10, 1'b0}); // auipc x10
        vecs.push_back('{32'h01F2_1213, 6'd25, 32'h0000_001F, 5'd4,  1'b0}); // slli x4,x4,31
        vecs.push_back('{32'h0FF0_000F, 6'd38, 32'h0000_0000, 5'd0,  1'b0}); // fence
        vecs.push_back('{32'h0050_0090, 6'd0,  32'h0000_0000, 5'd1,  1'b1}); // low bits 00
        vecs.push_back('{32'h0073_72B3, 6'd37, 32'h0000_0000, 5'd5,  1'b0}); // and x5,x6,x7

        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'd0;
        bus.in_pc     = 32'd0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_ill_cnt",   {24'd0, bus.ill_cnt},   32'd0);
        check("rst_out_op",    {26'd0, bus.out_op},    32'd0);
        check("rst_out_imm",   bus.out_imm,            32'd0);
        check("rst_out_pc",    bus.out_pc,             32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Main table, back-to-back with out_ready held high.
        for (int i = 0; i < vecs.size(); i++) begin
            inst = vecs[i].inst;
            apply(inst, 32'h0000_1000 + 32'(i * 4));
            if (vecs[i].ill) exp_cnt++;
            check($sformatf("v%0d_valid", i),   {31'd0, bus.out_valid},   32'd1);
            check($sformatf("v%0d_op", i),      {26'd0, bus.out_op},      {26'd0, vecs[i].op});
            check($sformatf("v%0d_imm", i),     bus.out_imm,              vecs[i].imm);
            check($sformatf("v%0d_rd", i),      {27'd0, bus.out_rd},      {27'd0, vecs[i].rd});
            check($sformatf("v%0d_rs1", i),     {27'd0, bus.out_rs1},     {27'd0, inst[19:15]});
            check($sformatf("v%0d_rs2", i),     {27'd0, bus.out_rs2},     {27'd0, inst[24:20]});
            check($sformatf("v%0d_pc", i),      bus.out_pc,               32'h0000_1000 + 32'(i * 4));
            check($sformatf("v%0d_illegal", i), {31'd0, bus.out_illegal}, {31'd0, vecs[i].ill});
            check($sformatf("v%0d_ill_cnt", i), {24'd0, bus.ill_cnt},     32'(exp_cnt));
        end
        @(posedge clk);
        #1;
        check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // Stall: A accepted, B waits three cycles, then both delivered in order.
        @(negedge clk);
        xfer_cnt      = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h0050_0093;
        bus.in_pc     = 32'h0000_2000;
        @(posedge clk);
        #1;
        bus.in_inst = 32'h1234_52B7;
        bus.in_pc   = 32'h0000_2004;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_valid",    {31'd0, bus.out_valid}, 32'd1);
            check("stall_op",       {26'd0, bus.out_op},   32'd19);
            check("stall_imm",      bus.out_imm,           32'd5);
            check("stall_pc",       bus.out_pc,            32'h0000_2000);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("release_valid", {31'd0, bus.out_valid}, 32'd1);
        check("release_op",    {26'd0, bus.out_op},    32'd1);
        check("release_imm",   bus.out_imm,            32'h1234_5000);
        check("release_rd",    {27'd0, bus.out_rd},    32'd5);
        check("release_pc",    bus.out_pc,             32'h0000_2004);
        @(posedge clk);
        #1;
        check("stall_drain_valid", {31'd0, bus.out_valid}, 32'd0);
        check("stall_xfer_cnt",    32'(xfer_cnt),          32'd2);

        // Flush with held output, stalled consumer and a pending illegal input.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h0000_0000;
        @(posedge clk);
        #1;
        exp_cnt++;
        check("pre_flush_valid",   {31'd0, bus.out_valid}, 32'd1);
        check("pre_flush_ill_cnt", {24'd0, bus.ill_cnt},   32'(exp_cnt));
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_valid",   {31'd0, bus.out_valid}, 32'd0);
        check("flush_ill_cnt", {24'd0, bus.ill_cnt},   32'(exp_cnt));
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // Saturation: 300 illegal instructions back to back.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h0000_0000;
        repeat (300) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_cnt = (exp_cnt + 300 > 255) ? 255 : exp_cnt + 300;
        check("sat_ill_cnt", {24'd0, bus.ill_cnt}, 32'(exp_cnt));
        @(posedge clk);
        #1;
        check("sat_hold_ill_cnt", {24'd0, bus.ill_cnt}, 32'd255);

        // Asynchronous reset in the middle of a stall.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h0050_0093;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("mid_stall_valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid",    {31'd0, bus.out_valid}, 32'd0);
        check("async_rst_ill_cnt",  {24'd0, bus.ill_cnt},   32'd0);
        check("async_rst_op",       {26'd0, bus.out_op},    32'd0);
        check("async_rst_in_ready", {31'd0, bus.in_ready},  32'd1);
        @(negedge clk);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
